// File: rtl/stage_sequencer.sv
// stage_sequencer: sequences one instruction through up to NUM_STAGES stages.
// Stages may be skipped through a per-instruction skip mask and held with stall.
// The mask is sampled while STG(0) is active.
//
// Ports
//   clk          single clock; all state changes on its rising edge
//   rst          asynchronous active-low reset
//   run          free-running: start a new instruction after every completed one
//   step         single-cycle pulse: start exactly one instruction from idle
//   halt         block the next start; never aborts an instruction in flight
//   stall        hold the current stage (strobe stays asserted)
//   skip_mask    per-stage skip request, bit 0 ignored
//   stage_oh     one-hot strobe of the active stage, zero when idle
//   stage_idx    index of the active stage, zero when idle
//   busy         high while any stage is active
//   instr_done   high on the final cycle of an instruction
//   instr_count  retired-instruction counter (wraps)
module stage_sequencer #(
  parameter int unsigned NUM_STAGES = 5,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  step,
  input  logic                  halt,
  input  logic                  stall,
  input  logic [NUM_STAGES-1:0] skip_mask,
  output logic [NUM_STAGES-1:0] stage_oh,
  output logic [2:0]            stage_idx,
  output logic                  busy,
  output logic                  instr_done,
  output logic [CNT_W-1:0]      instr_count
);

  // Encoding: 0 is idle, k+1 is STG(k). Anything above ST_LAST is illegal.
  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_STG0 = 4'd1;
  localparam logic [3:0] ST_LAST = 4'(NUM_STAGES);

  logic [3:0]            state_q, state_d;
  logic [NUM_STAGES-1:0] skip_q, skip_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic                  in_stage;
  logic [2:0]            cur;
  logic [NUM_STAGES-1:0] eff_skip;
  logic                  found;
  logic [2:0]            nxt;

  // Moore decode of the state register
  always_comb begin
    in_stage = (state_q >= ST_STG0) && (state_q <= ST_LAST);
    cur      = in_stage ? 3'(state_q - ST_STG0) : 3'd0;
  end

  assign busy      = in_stage;
  assign stage_idx = cur;
  assign stage_oh  = in_stage ? (NUM_STAGES'(1) << cur) : '0;

  // STG(0) steers by the live mask because skip_q is only loaded when leaving it.
  always_comb begin
    if (cur == 3'd0) begin
      eff_skip    = skip_mask;
      eff_skip[0] = 1'b0;
    end else begin
      eff_skip = skip_q;
    end
  end

  // Smallest non-skipped stage above the current one; scanning downwards
  // leaves the lowest match in nxt.
  always_comb begin
    found = 1'b0;
    nxt   = 3'd0;
    for (int j = NUM_STAGES - 1; j >= 1; j--) begin
      if ((j > int'(cur)) && !eff_skip[j]) begin
        found = 1'b1;
        nxt   = 3'(j);
      end
    end
  end

  assign instr_done = in_stage && !stall && !found;

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    count_d = count_q;
    if (!in_stage) begin
      // Idle, or an illegal encoding that falls back to idle
      state_d = ST_IDLE;
      if ((state_q == ST_IDLE) && (run || step) && !halt) begin
        state_d = ST_STG0;
      end
    end else if (!stall) begin
      if (cur == 3'd0) begin
        skip_d = eff_skip;
      end
      if (found) begin
        state_d = 4'(nxt) + ST_STG0;
      end else if (run && !halt) begin
        state_d = ST_STG0;
      end else begin
        state_d = ST_IDLE;
      end
    end
    if (instr_done) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      skip_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      count_q <= count_d;
    end
  end

  assign instr_count = count_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer with NUM_STAGES=5 and a 4-bit counter
// so that counter wrap can be reached quickly.
module tb_stage_sequencer;

  localparam int NS = 5;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          run;
  logic          step;
  logic          halt;
  logic          stall;
  logic [NS-1:0] skip_mask;
  logic [NS-1:0] stage_oh;
  logic [2:0]    stage_idx;
  logic          busy;
  logic          instr_done;
  logic [CW-1:0] instr_count;

  int checks   = 0;
  int failures = 0;

  stage_sequencer #(
    .NUM_STAGES(NS),
    .CNT_W     (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .step       (step),
    .halt       (halt),
    .stall      (stall),
    .skip_mask  (skip_mask),
    .stage_oh   (stage_oh),
    .stage_idx  (stage_idx),
    .busy       (busy),
    .instr_done (instr_done),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one edge and settle just after it
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // k < 0 means idle
  task automatic expect_stage(input string tag, input int k, input logic done);
    logic [31:0] oh;
    oh = (k < 0) ? 32'd0 : (32'd1 << k);
    check_eq({tag, ".oh"}, 32'(stage_oh), oh);
    check_eq({tag, ".idx"}, 32'(stage_idx), (k < 0) ? 32'd0 : 32'(k));
    check_eq({tag, ".busy"}, 32'(busy), (k < 0) ? 32'd0 : 32'd1);
    check_eq({tag, ".done"}, 32'(instr_done), 32'(done));
  endtask

  initial begin
    rst       = 1'b0;
    run       = 1'b0;
    step      = 1'b0;
    halt      = 1'b0;
    stall     = 1'b0;
    skip_mask = '0;

    // Reset state
    cyc();
    cyc();
    expect_stage("reset", -1, 1'b0);
    check_eq("reset.cnt", 32'(instr_count), 32'd0);
    rst = 1'b1;
    cyc();
    expect_stage("post_reset_idle", -1, 1'b0);

    // Free-running without skips: three back-to-back instructions
    run = 1'b1;
    for (int c = 0; c < 15; c++) begin
      cyc();
      expect_stage($sformatf("run%0d", c), c % 5, (c % 5) == 4);
      if (c == 14) run = 1'b0;
    end
    cyc();
    expect_stage("run_end", -1, 1'b0);
    check_eq("run_end.cnt", 32'(instr_count), 32'd3);

    // Skip stage 3; later mask changes must not matter
    skip_mask = 5'b01000;
    run       = 1'b1;
    cyc();
    expect_stage("skip3.s0", 0, 1'b0);
    cyc();
    expect_stage("skip3.s1", 1, 1'b0);
    skip_mask = 5'b00000;
    cyc();
    expect_stage("skip3.s2", 2, 1'b0);
    skip_mask = 5'b11111;
    run       = 1'b0;
    cyc();
    expect_stage("skip3.s4", 4, 1'b1);
    cyc();
    expect_stage("skip3.end", -1, 1'b0);
    check_eq("skip3.cnt", 32'(instr_count), 32'd4);
    skip_mask = '0;

    // Stall three cycles in STG(2), then stall on the final stage briefly
    run = 1'b1;
    cyc();
    expect_stage("stall.s0", 0, 1'b0);
    cyc();
    expect_stage("stall.s1", 1, 1'b0);
    cyc();
    expect_stage("stall.s2", 2, 1'b0);
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cyc();
      expect_stage($sformatf("stall.hold%0d", c), 2, 1'b0);
    end
    stall = 1'b0;
    cyc();
    expect_stage("stall.s3", 3, 1'b0);
    run = 1'b0;
    cyc();
    expect_stage("stall.s4", 4, 1'b1);
    stall = 1'b1;
    #1;
    check_eq("stall.final_done", 32'(instr_done), 32'd0);
    stall = 1'b0;
    #1;
    check_eq("stall.final_undone", 32'(instr_done), 32'd1);
    cyc();
    expect_stage("stall.end", -1, 1'b0);
    check_eq("stall.cnt", 32'(instr_count), 32'd5);

    // Single step; a second step while busy is ignored
    step = 1'b1;
    cyc();
    expect_stage("step.s0", 0, 1'b0);
    step = 1'b0;
    cyc();
    expect_stage("step.s1", 1, 1'b0);
    step = 1'b1;
    cyc();
    expect_stage("step.s2", 2, 1'b0);
    step = 1'b0;
    cyc();
    expect_stage("step.s3", 3, 1'b0);
    cyc();
    expect_stage("step.s4", 4, 1'b1);
    cyc();
    expect_stage("step.end", -1, 1'b0);
    check_eq("step.cnt", 32'(instr_count), 32'd6);
    cyc();
    expect_stage("step.stay_idle", -1, 1'b0);

    // halt in idle blocks both run and step
    halt = 1'b1;
    run  = 1'b1;
    step = 1'b1;
    cyc();
    expect_stage("halt_idle0", -1, 1'b0);
    cyc();
    expect_stage("halt_idle1", -1, 1'b0);
    step = 1'b0;
    halt = 1'b0;

    // halt during STG(1) lets the instruction finish
    cyc();
    expect_stage("halt.s0", 0, 1'b0);
    cyc();
    expect_stage("halt.s1", 1, 1'b0);
    halt = 1'b1;
    cyc();
    expect_stage("halt.s2", 2, 1'b0);
    cyc();
    expect_stage("halt.s3", 3, 1'b0);
    cyc();
    expect_stage("halt.s4", 4, 1'b1);
    cyc();
    expect_stage("halt.end", -1, 1'b0);
    check_eq("halt.cnt", 32'(instr_count), 32'd7);
    cyc();
    expect_stage("halt.stay_idle", -1, 1'b0);
    halt = 1'b0;

    // Asynchronous reset in STG(3)
    cyc();
    expect_stage("arst.s0", 0, 1'b0);
    cyc();
    cyc();
    cyc();
    expect_stage("arst.s3", 3, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    expect_stage("arst.now", -1, 1'b0);
    check_eq("arst.cnt", 32'(instr_count), 32'd0);
    run = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    expect_stage("arst.after", -1, 1'b0);
    check_eq("arst.after_cnt", 32'(instr_count), 32'd0);

    // All stages but 0 skipped: one-cycle instructions, counter wraps at 16
    skip_mask = 5'b11110;
    run       = 1'b1;
    for (int i = 0; i < 18; i++) begin
      cyc();
      expect_stage($sformatf("min%0d", i), 0, 1'b1);
      check_eq($sformatf("min%0d.cnt", i), 32'(instr_count), 32'(i % 16));
    end
    run = 1'b0;
    cyc();
    expect_stage("min.end", -1, 1'b0);
    check_eq("min.end_cnt", 32'(instr_count), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
